// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// rtl/mem_port_arbiter_prio.sv - data-first grant decision with fetch starvation counter
module mem_port_arbiter_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst,
    input  logic if_eligible_i,
    input  logic dm_req_i,
    input  logic grant_i,
    output logic grant_if_o
);

    localparam int            CW      = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    always_comb begin
        grant_if_o   = if_eligible_i & (~dm_req_i | (starve_cnt_q == CNT_MAX));
        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            if (grant_if_o) begin
                starve_cnt_d = '0;
            end else if (if_eligible_i && (starve_cnt_q != CNT_MAX)) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and the memory stage
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [PC_WIDTH-1:0] if_addr_i,
    input  logic                if_flush_i,
    output logic                if_rvalid_o,
    output logic [XLEN-1:0]     if_rdata_o,
    output logic                if_busy_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [3:0]          dm_wstrb_i,
    input  logic [XLEN-1:0]     dm_addr_i,
    input  logic [XLEN-1:0]     dm_wdata_i,
    output logic                dm_rvalid_o,
    output logic [XLEN-1:0]     dm_rdata_o,
    output logic                dm_busy_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_wstrb_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            drop_q, drop_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic if_eligible;
    logic grant;
    logic grant_if;
    logic resp;

    assign if_eligible = if_req_i & ~if_flush_i;

    mem_port_arbiter_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i         (clk_i),
        .rst           (rst),
        .if_eligible_i (if_eligible),
        .dm_req_i      (dm_req_i),
        .grant_i       (grant),
        .grant_if_o    (grant_if)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_eligible || dm_req_i) begin
                    grant   = 1'b1;
                    state_d = ARB_ISSUE;
                    drop_d  = 1'b0;
                    if (grant_if) begin
                        owner_d = OWN_IF;
                        we_d    = 1'b0;
                        wstrb_d = '0;
                        addr_d  = XLEN'(if_addr_i);
                        wdata_d = '0;
                    end else begin
                        owner_d = OWN_DM;
                        we_d    = dm_we_i;
                        wstrb_d = dm_wstrb_i;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                    end
                end
            end
            ARB_ISSUE: if (mem_gnt_i) state_d = ARB_WAIT;
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        // A redirected fetch still drains on the memory side; only its response is hidden.
        if (if_flush_i && (owner_q == OWN_IF) &&
            ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT))) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign resp        = (state_q == ARB_RESP);
    assign mem_req_o   = (state_q == ARB_ISSUE);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_wstrb_o = mem_req_o ? wstrb_q : '0;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;

    assign if_rvalid_o = resp & (owner_q == OWN_IF) & ~drop_q & ~if_flush_i;
    assign dm_rvalid_o = resp & (owner_q == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? rdata_q : '0;
    assign dm_rdata_o  = (dm_rvalid_o & ~we_q) ? rdata_q : '0;
    assign if_busy_o   = if_req_i & ~if_rvalid_o;
    assign dm_busy_o   = dm_req_i & ~dm_rvalid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        if_req_i, if_flush_i, if_rvalid_o, if_busy_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_rvalid_o, dm_busy_o;
    logic [3:0]  dm_wstrb_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_busy_o(if_busy_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_wstrb_i(dm_wstrb_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_busy_o(dm_busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct packed {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_wstrb;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
    } ins_t;

    typedef struct packed {
        logic        if_rv;
        logic [31:0] if_rd;
        logic        if_busy;
        logic        dm_rv;
        logic [31:0] dm_rd;
        logic        dm_busy;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    typedef struct packed {
        ins_t  stim;
        outs_t want;
    } vec_t;

    vec_t  vecs[$];
    ins_t  vi;
    outs_t vo;
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic ins_t in_idle();
        ins_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic ins_t in_if(input logic [31:0] a);
        ins_t s = in_idle();
        s.if_req  = 1'b1;
        s.if_addr = a;
        return s;
    endfunction

    function automatic ins_t in_dm(input logic we, input logic [3:0] ws,
                                   input logic [31:0] a, input logic [31:0] d);
        ins_t s = in_idle();
        s.dm_req   = 1'b1;
        s.dm_we    = we;
        s.dm_wstrb = ws;
        s.dm_addr  = a;
        s.dm_wdata = d;
        return s;
    endfunction

    function automatic outs_t out_mem(input logic we, input logic [3:0] ws,
                                      input logic [31:0] a, input logic [31:0] d);
        outs_t o = '0;
        o.mem_req   = 1'b1;
        o.mem_we    = we;
        o.mem_wstrb = ws;
        o.mem_addr  = a;
        o.mem_wdata = d;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.if_rv     = if_rvalid_o;
        o.if_rd     = if_rdata_o;
        o.if_busy   = if_busy_o;
        o.dm_rv     = dm_rvalid_o;
        o.dm_rd     = dm_rdata_o;
        o.dm_busy   = dm_busy_o;
        o.mem_req   = mem_req_o;
        o.mem_we    = mem_we_o;
        o.mem_wstrb = mem_wstrb_o;
        o.mem_addr  = mem_addr_o;
        o.mem_wdata = mem_wdata_o;
        return o;
    endfunction

    task automatic push();
        vec_t v;
        v.stim = vi;
        v.want = vo;
        vecs.push_back(v);
    endtask

    task automatic apply(input ins_t s);
        rst          = s.rst;
        if_req_i     = s.if_req;
        if_addr_i    = s.if_addr;
        if_flush_i   = s.if_flush;
        dm_req_i     = s.dm_req;
        dm_we_i      = s.dm_we;
        dm_wstrb_i   = s.dm_wstrb;
        dm_addr_i    = s.dm_addr;
        dm_wdata_i   = s.dm_wdata;
        mem_gnt_i    = s.gnt;
        mem_rvalid_i = s.rv;
        mem_rdata_i  = s.rdata;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [9:0] exp_order;
    logic       pend;
    int         ng;

    initial begin
        // Reset, mid-WAIT reset, stray rvalid
        vi = in_idle(); vi.rst = 1'b0; vo = '0; push();
        vi = in_dm(1'b0, 4'h0, 32'h40, 32'h0); vo = '0; vo.dm_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'h0, 32'h40, 32'h0); vo.dm_busy = 1'b1; push();
        vi = in_idle(); vi.rst = 1'b0; vo = '0; push();
        vi = in_idle(); vi.rv = 1'b1; vi.rdata = 32'hDEAD_BEEF; vo = '0; push();
        vi = in_idle(); vo = '0; push();
        // Lone fetch, minimum latency
        vi = in_if(32'h100); vo = '0; vo.if_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'h0, 32'h100, 32'h0); vo.if_busy = 1'b1; push();
        vi = in_if(32'h100); vi.rv = 1'b1; vi.rdata = 32'h13; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_if(32'h100); vo = '0; vo.if_rv = 1'b1; vo.if_rd = 32'h13; push();
        vi = in_idle(); vo = '0; push();
        // Store with grant delayed three cycles
        vi = in_dm(1'b1, 4'b0011, 32'h2004, 32'hBEEF); vo = '0; vo.dm_busy = 1'b1; push();
        for (int k = 0; k < 4; k++) begin
            vi.gnt = (k == 3); vo = out_mem(1'b1, 4'b0011, 32'h2004, 32'hBEEF); vo.dm_busy = 1'b1; push();
        end
        vi.gnt = 1'b0; vi.rv = 1'b1; vi.rdata = 32'h1234_5678; vo = '0; vo.dm_busy = 1'b1; push();
        vi.rv = 1'b0; vo = '0; vo.dm_rv = 1'b1; push();
        vi = in_idle(); vo = '0; push();
        // Fetch flushed in WAIT, then a clean fetch
        vi = in_if(32'h200); vo = '0; vo.if_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'h0, 32'h200, 32'h0); vo.if_busy = 1'b1; push();
        vi = in_if(32'h200); vi.if_flush = 1'b1; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_idle(); vi.rv = 1'b1; vi.rdata = 32'h77; vo = '0; push();
        vi = in_idle(); vo = '0; push();
        vi = in_if(32'h300); vo = '0; vo.if_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'h0, 32'h300, 32'h0); vo.if_busy = 1'b1; push();
        vi = in_if(32'h300); vi.rv = 1'b1; vi.rdata = 32'h99; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_if(32'h300); vo = '0; vo.if_rv = 1'b1; vo.if_rd = 32'h99; push();
        vi = in_idle(); vo = '0; push();
        // Fetch with flush in the same cycle is not eligible
        vi = in_if(32'h400); vi.if_flush = 1'b1; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_idle(); vo = '0; push();
        // Flush during RESP hides the fetch response
        vi = in_if(32'h500); vo = '0; vo.if_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'h0, 32'h500, 32'h0); vo.if_busy = 1'b1; push();
        vi = in_if(32'h500); vi.rv = 1'b1; vi.rdata = 32'h55; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_if(32'h500); vi.if_flush = 1'b1; vo = '0; vo.if_busy = 1'b1; push();
        vi = in_idle(); vo = '0; push();
        // Load unaffected by flush
        vi = in_dm(1'b0, 4'hF, 32'h80, 32'h0); vo = '0; vo.dm_busy = 1'b1; push();
        vi.gnt = 1'b1; vo = out_mem(1'b0, 4'hF, 32'h80, 32'h0); vo.dm_busy = 1'b1; push();
        vi.gnt = 1'b0; vi.if_flush = 1'b1; vi.rv = 1'b1; vi.rdata = 32'hCAFE_F00D; vo = '0; vo.dm_busy = 1'b1; push();
        vi.if_flush = 1'b0; vi.rv = 1'b0; vo = '0; vo.dm_rv = 1'b1; vo.dm_rd = 32'hCAFE_F00D; push();
        vi = in_idle(); vo = '0; push();

        vi = in_idle(); vi.rst = 1'b0;
        apply(vi);
        cycle();
        cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            outs_t act;
            apply(vecs[i].stim);
            @(negedge clk_i);
            act = sample();
            n_vec++;
            if (act !== vecs[i].want) begin
                n_bad++;
                $display("FAIL vec%0d: got %h expected %h", i, act, vecs[i].want);
            end
            cycle();
        end

        // Flush with mem_rvalid_i while data is pending; data wins the next IDLE
        vi = in_if(32'h600); apply(vi); cycle();
        vi.gnt = 1'b1; vi.dm_req = 1'b1; vi.dm_wstrb = 4'hF; vi.dm_addr = 32'h700; apply(vi); cycle();
        vi = in_dm(1'b0, 4'hF, 32'h700, 32'h0); vi.if_flush = 1'b1; vi.rv = 1'b1; vi.rdata = 32'h11;
        apply(vi); cycle();
        vi = in_dm(1'b0, 4'hF, 32'h700, 32'h0); apply(vi);
        @(negedge clk_i);
        check_val("t6_if_rvalid_dropped", 32'(if_rvalid_o), 32'h0);
        check_val("t6_dm_rvalid_resp", 32'(dm_rvalid_o), 32'h0);
        cycle();
        @(negedge clk_i);
        check_val("t6_idle_no_req", 32'(mem_req_o), 32'h0);
        cycle();
        @(negedge clk_i);
        check_val("t6_data_req", 32'(mem_req_o), 32'h1);
        check_val("t6_data_addr", mem_addr_o, 32'h700);
        vi.gnt = 1'b1; apply(vi); cycle();
        vi.gnt = 1'b0; vi.rv = 1'b1; vi.rdata = 32'h4242; apply(vi); cycle();
        vi.rv = 1'b0; apply(vi);
        @(negedge clk_i);
        check_val("t6_dm_rvalid", 32'(dm_rvalid_o), 32'h1);
        check_val("t6_dm_rdata", dm_rdata_o, 32'h4242);
        cycle();

        // Starvation: both requesters held, expect D,D,D,D,I,D,D,D,D,I
        vi = in_idle(); vi.rst = 1'b0; apply(vi); cycle();
        vi = in_dm(1'b0, 4'hF, 32'hA00, 32'h0); vi.if_req = 1'b1; vi.if_addr = 32'h900;
        exp_order = 10'b10_0001_0000;
        pend = 1'b0;
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            vi.gnt   = mem_req_o;
            vi.rv    = pend;
            vi.rdata = 32'h13;
            apply(vi);
            if (mem_req_o) begin
                check_val($sformatf("t3_grant%0d_is_fetch", ng), 32'(mem_addr_o == 32'h900),
                          32'(exp_order[ng]));
                ng++;
            end
            pend = mem_req_o;
            cycle();
        end
        check_val("t3_grant_count", 32'(ng), 32'd10);

        vi = in_idle(); apply(vi); cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
